// File: rtl/panda_top_bench.sv
// Position-capture event sequencer: synchronises the bench controls and turns them into
// the timestamped frame/capture stream, counters, sticky framing errors and completion irq.
module panda_top_bench #(
    parameter int TS_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             pcap_armed,
    input  logic             enable,
    input  logic             frame,
    input  logic             capture,
    output logic             active_o,
    output logic             frame_o,
    output logic [TS_W-1:0]  frame_length_o,
    output logic             capture_o,
    output logic [TS_W-1:0]  sample_o,
    output logic [CNT_W-1:0] smpl_count_o,
    output logic [TS_W-1:0]  frame_count_o,
    output logic [1:0]       err_o,
    output logic             irq_o
);

    // Synchroniser bit order: 0 armed, 1 enable, 2 frame, 3 capture.
    logic [3:0] s1_q, s2_q, s3_q;
    logic [3:0] rise;

    logic             active_q, active_d;
    logic             frame_o_q, frame_o_d;
    logic             capture_o_q, capture_o_d;
    logic             irq_q, irq_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  flen_cnt_q, flen_cnt_d;
    logic [TS_W-1:0]  frame_length_q, frame_length_d;
    logic [TS_W-1:0]  sample_q, sample_d;
    logic [CNT_W-1:0] smpl_count_q, smpl_count_d;
    logic [TS_W-1:0]  frame_count_q, frame_count_d;
    logic [1:0]       err_q, err_d;
    logic             have_frame_q, have_frame_d;
    logic             captured_q, captured_d;

    assign rise = s2_q & ~s3_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            s1_q <= {capture, frame, enable, pcap_armed};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a variable unassigned (no latch).
        active_d       = active_q;
        frame_o_d      = 1'b0;
        capture_o_d    = 1'b0;
        irq_d          = 1'b0;
        ts_d           = ts_q;
        flen_cnt_d     = flen_cnt_q;
        frame_length_d = frame_length_q;
        sample_d       = sample_q;
        smpl_count_d   = smpl_count_q;
        frame_count_d  = frame_count_q;
        err_d          = err_q;
        have_frame_d   = have_frame_q;
        captured_d     = captured_q;

        if (!active_q) begin
            if (s2_q[0] && rise[1]) begin
                active_d      = 1'b1;
                ts_d          = '0;
                flen_cnt_d    = '0;
                smpl_count_d  = '0;
                frame_count_d = '0;
                err_d         = '0;
                have_frame_d  = 1'b0;
                captured_d    = 1'b0;
            end
        end else if (!s2_q[0] || !s2_q[1]) begin
            // Deactivation wins over any edge decoded in the same cycle.
            active_d = 1'b0;
            irq_d    = 1'b1;
        end else begin
            ts_d       = ts_q + TS_W'(1);
            flen_cnt_d = flen_cnt_q + TS_W'(1);
            if (rise[2]) begin
                frame_o_d      = 1'b1;
                frame_length_d = flen_cnt_q + TS_W'(1);
                flen_cnt_d     = '0;
                frame_count_d  = frame_count_q + TS_W'(1);
                have_frame_d   = 1'b1;
                captured_d     = 1'b0;
            end
            // Uses the post-frame flags so a coincident frame opens a fresh frame for this capture.
            if (rise[3]) begin
                if (!have_frame_d) begin
                    err_d[0] = 1'b1;
                end else begin
                    if (captured_d) err_d[1] = 1'b1;
                    capture_o_d  = 1'b1;
                    sample_d     = ts_q;
                    smpl_count_d = smpl_count_q + CNT_W'(1);
                    captured_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            active_q       <= 1'b0;
            frame_o_q      <= 1'b0;
            capture_o_q    <= 1'b0;
            irq_q          <= 1'b0;
            ts_q           <= '0;
            flen_cnt_q     <= '0;
            frame_length_q <= '0;
            sample_q       <= '0;
            smpl_count_q   <= '0;
            frame_count_q  <= '0;
            err_q          <= '0;
            have_frame_q   <= 1'b0;
            captured_q     <= 1'b0;
        end else begin
            active_q       <= active_d;
            frame_o_q      <= frame_o_d;
            capture_o_q    <= capture_o_d;
            irq_q          <= irq_d;
            ts_q           <= ts_d;
            flen_cnt_q     <= flen_cnt_d;
            frame_length_q <= frame_length_d;
            sample_q       <= sample_d;
            smpl_count_q   <= smpl_count_d;
            frame_count_q  <= frame_count_d;
            err_q          <= err_d;
            have_frame_q   <= have_frame_d;
            captured_q     <= captured_d;
        end
    end

    assign active_o       = active_q;
    assign frame_o        = frame_o_q;
    assign frame_length_o = frame_length_q;
    assign capture_o      = capture_o_q;
    assign sample_o       = sample_q;
    assign smpl_count_o   = smpl_count_q;
    assign frame_count_o  = frame_count_q;
    assign err_o          = err_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_panda_top_bench.sv
// Directed bench for panda_top_bench: strobes are logged by a negedge monitor and
// compared against hand-computed lengths, timestamps, counters and error codes.
module tb_panda_top_bench;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        pcap_armed = 1'b0;
    logic        enable = 1'b0;
    logic        frame = 1'b0;
    logic        capture = 1'b0;
    logic        active_o;
    logic        frame_o;
    logic [31:0] frame_length_o;
    logic        capture_o;
    logic [31:0] sample_o;
    logic [15:0] smpl_count_o;
    logic [31:0] frame_count_o;
    logic [1:0]  err_o;
    logic        irq_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] flen_log[$];
    logic [31:0] samp_log[$];
    int          irq_cnt  = 0;
    int          both_cnt = 0;
    int          irq_base;

    panda_top_bench #(.TS_W(32), .CNT_W(16)) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .pcap_armed     (pcap_armed),
        .enable         (enable),
        .frame          (frame),
        .capture        (capture),
        .active_o       (active_o),
        .frame_o        (frame_o),
        .frame_length_o (frame_length_o),
        .capture_o      (capture_o),
        .sample_o       (sample_o),
        .smpl_count_o   (smpl_count_o),
        .frame_count_o  (frame_count_o),
        .err_o          (err_o),
        .irq_o          (irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (frame_o) flen_log.push_back(frame_length_o);
        if (capture_o) samp_log.push_back(sample_o);
        if (irq_o) irq_cnt++;
        if (frame_o && capture_o) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " active"}, 32'(active_o), 32'd0);
        check({tag, " strobes"}, {29'd0, frame_o, capture_o, irq_o}, 32'd0);
        check({tag, " frame_length"}, frame_length_o, 32'd0);
        check({tag, " sample"}, sample_o, 32'd0);
        check({tag, " smpl_count"}, 32'(smpl_count_o), 32'd0);
        check({tag, " frame_count"}, frame_count_o, 32'd0);
        check({tag, " err"}, 32'(err_o), 32'd0);
    endtask

    task automatic clear_logs();
        flen_log.delete();
        samp_log.delete();
        both_cnt = 0;
    endtask

    initial begin
        // Reset held while inputs toggle.
        for (int c = 0; c < 8; c++) begin
            pcap_armed = c[0];
            enable     = c[1];
            frame      = ~c[0];
            capture    = c[2];
            step(1);
        end
        check_all_zero("in_reset");
        {pcap_armed, enable, frame, capture} = 4'b0000;
        reset_n_i = 1'b1;
        step(6);
        check_all_zero("after_reset");

        // Arm, frame at 10, captures at 15 and 25 (same frame).
        pcap_armed = 1'b1;
        step(4);
        clear_logs();
        for (int c = 0; c < 30; c++) begin
            enable  = 1'b1;
            frame   = (c == 10 || c == 11);
            capture = (c == 15 || c == 16 || c == 25 || c == 26);
            step(1);
        end
        {frame, capture} = 2'b00;
        step(5);
        check("t1 active", 32'(active_o), 32'd1);
        check("t1 frames", 32'(flen_log.size()), 32'd1);
        if (flen_log.size() == 1) check("t1 frame_length", flen_log[0], 32'd10);
        check("t1 captures", 32'(samp_log.size()), 32'd2);
        if (samp_log.size() == 2) begin
            check("t1 sample0", samp_log[0], 32'd14);
            check("t1 sample1", samp_log[1], 32'd24);
        end
        check("t1 err", 32'(err_o), 32'd2);
        check("t1 smpl_count", 32'(smpl_count_o), 32'd2);
        check("t1 frame_count", frame_count_o, 32'd1);
        enable = 1'b0;
        step(6);
        check("t1 deactive", 32'(active_o), 32'd0);
        check("t1 irq once", 32'(irq_cnt), 32'd1);
        check("t1 smpl hold", 32'(smpl_count_o), 32'd2);

        // Capture before any frame.
        clear_logs();
        for (int c = 0; c < 12; c++) begin
            enable  = 1'b1;
            capture = (c == 5);
            step(1);
        end
        step(4);
        check("t2 err", 32'(err_o), 32'd1);
        check("t2 captures", 32'(samp_log.size()), 32'd0);
        check("t2 smpl_count", 32'(smpl_count_o), 32'd0);
        enable = 1'b0;
        step(6);

        // Five frames of 8 cycles, one capture each.
        clear_logs();
        for (int c = 0; c < 50; c++) begin
            enable  = 1'b1;
            frame   = (c % 8 == 0) && (c > 0) && (c <= 40);
            capture = (c % 8 == 4) && (c >= 12) && (c <= 44);
            step(1);
        end
        {frame, capture} = 2'b00;
        step(5);
        check("t3 frame_count", frame_count_o, 32'd5);
        check("t3 smpl_count", 32'(smpl_count_o), 32'd5);
        check("t3 err", 32'(err_o), 32'd0);
        check("t3 frames", 32'(flen_log.size()), 32'd5);
        foreach (flen_log[i]) check($sformatf("t3 frame_length%0d", i), flen_log[i], 32'd8);
        check("t3 captures", 32'(samp_log.size()), 32'd5);
        foreach (samp_log[i]) check($sformatf("t3 sample%0d", i), samp_log[i], 32'(11 + 8 * i));
        enable = 1'b0;
        step(6);

        // Frame and capture decoded in the same cycle.
        clear_logs();
        for (int c = 0; c < 12; c++) begin
            enable  = 1'b1;
            frame   = (c == 6);
            capture = (c == 6);
            step(1);
        end
        {frame, capture} = 2'b00;
        step(4);
        check("t4 coincident", 32'(both_cnt), 32'd1);
        check("t4 err", 32'(err_o), 32'd0);
        check("t4 smpl_count", 32'(smpl_count_o), 32'd1);
        if (flen_log.size() == 1) check("t4 frame_length", flen_log[0], 32'd6);
        else check("t4 frames", 32'(flen_log.size()), 32'd1);
        if (samp_log.size() == 1) check("t4 sample", samp_log[0], 32'd5);
        else check("t4 captures", 32'(samp_log.size()), 32'd1);

        // Disarm mid-run, then edges are ignored and counters hold.
        irq_base   = irq_cnt;
        pcap_armed = 1'b0;
        step(6);
        check("t5 deactive", 32'(active_o), 32'd0);
        check("t5 irq once", 32'(irq_cnt - irq_base), 32'd1);
        clear_logs();
        for (int c = 0; c < 10; c++) begin
            frame   = (c == 2);
            capture = (c == 5);
            step(1);
        end
        step(4);
        check("t5 no strobes", 32'(flen_log.size() + samp_log.size()), 32'd0);
        check("t5 frame_count hold", frame_count_o, 32'd1);
        check("t5 smpl_count hold", 32'(smpl_count_o), 32'd1);
        enable     = 1'b0;
        pcap_armed = 1'b1;
        step(5);
        enable = 1'b1;
        step(5);
        check("t5 rearm active", 32'(active_o), 32'd1);
        check("t5 rearm smpl_count", 32'(smpl_count_o), 32'd0);
        check("t5 rearm frame_count", frame_count_o, 32'd0);
        check("t5 rearm err", 32'(err_o), 32'd0);

        // Asynchronous reset clears without a clock edge.
        #3;
        reset_n_i = 1'b0;
        #1;
        check("async reset active", 32'(active_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
